param_loop_scheduler: RTL and testbench

- Shares the single parameter-loop trigger line between NUM_REQ fabric requesters using round-robin arbitration.
- Sequences a four-phase handshake with the Nios parameter loop:
  - loop_trig is driven low (falling edge), which the CPU-side PIO edge-captures as an interrupt.
  - The CPU answers on loop_ack through its output PIO bit.
- Drives active_id so the CPU knows which requester's parameter block to service.
- Adds timeout recovery so a stalled CPU cannot lock out the fabric.

---
 rtl/param_loop_scheduler.sv | 160 ++++++++++++++++
 tb/tb_param_loop_scheduler.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_loop_scheduler.sv
// Round-robin scheduler that shares the Nios parameter-loop trigger line between
// fabric requesters and runs the four-phase trig/ack handshake with timeout recovery.
//
// state     | meaning
// ----------+------------------------------------------------------------------
// S_IDLE    | loop_trig high, waiting for any req; grants the next in rotation
// S_TRIG    | loop_trig low, waiting for the CPU to raise ack (or timeout)
// S_RELEASE | loop_trig high, waiting for the CPU to drop ack (or timeout)
// S_GAP     | loop_trig held high so the PIO edge capture sees a clean gap
module param_loop_scheduler #(
  parameter int NUM_REQ     = 4,
  parameter int ID_W        = 2,
  parameter int TIMEOUT_CYC = 65535,
  parameter int GAP_CYC     = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] done,
  output logic [NUM_REQ-1:0] err,
  output logic               busy,
  output logic [ID_W-1:0]    active_id,
  output logic               loop_trig,
  input  logic               loop_ack
);

  localparam int CNT_MAX = (TIMEOUT_CYC > GAP_CYC) ? TIMEOUT_CYC : GAP_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] TMO_LOAD = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [ID_W-1:0]  LAST_RST = ID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_TRIG,
    S_RELEASE,
    S_GAP
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   tmr;
  logic [ID_W-1:0]    last;
  logic               err_flag;
  logic               ack_meta;
  logic               ack_s;

  logic               grant_vld;
  logic [ID_W-1:0]    grant_id;
  logic               hi_vld;
  logic [ID_W-1:0]    hi_id;
  logic [ID_W-1:0]    lo_id;
  logic [NUM_REQ-1:0] served_oh;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ack_meta <= 1'b0;
      ack_s    <= 1'b0;
    end else begin
      ack_meta <= loop_ack;
      ack_s    <= ack_meta;
    end
  end

  // Lowest set request above the last grant wins; otherwise wrap to the lowest set request.
  always_comb begin
    hi_vld    = 1'b0;
    hi_id     = '0;
    lo_id     = '0;
    grant_vld = 1'b0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (req[j]) begin
        grant_vld = 1'b1;
        lo_id     = ID_W'(j);
        if (j > int'(last)) begin
          hi_vld = 1'b1;
          hi_id  = ID_W'(j);
        end
      end
    end
    grant_id = hi_vld ? hi_id : lo_id;
  end

  assign served_oh = NUM_REQ'(1) << active_id;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      tmr       <= '0;
      last      <= LAST_RST;
      err_flag  <= 1'b0;
      active_id <= '0;
      busy      <= 1'b0;
      loop_trig <= 1'b1;
      done      <= '0;
      err       <= '0;
    end else begin
      done <= '0;
      err  <= '0;
      case (state)
        S_IDLE: begin
          if (grant_vld) begin
            active_id <= grant_id;
            last      <= grant_id;
            busy      <= 1'b1;
            loop_trig <= 1'b0;
            tmr       <= TMO_LOAD;
            state     <= S_TRIG;
          end
        end

        S_TRIG: begin
          if (ack_s) begin
            loop_trig <= 1'b1;
            tmr       <= TMO_LOAD;
            state     <= S_RELEASE;
          end else if (tmr == '0) begin
            err_flag  <= 1'b1;
            loop_trig <= 1'b1;
            tmr       <= TMO_LOAD;
            state     <= S_RELEASE;
          end else begin
            tmr <= tmr - CNT_ONE;
          end
        end

        // A release timeout (ack still high at terminal count) also reports as an error.
        S_RELEASE: begin
          if (!ack_s || (tmr == '0)) begin
            if (err_flag || ack_s) begin
              err <= served_oh;
            end else begin
              done <= served_oh;
            end
            err_flag <= 1'b0;
            tmr      <= GAP_LOAD;
            state    <= S_GAP;
          end else begin
            tmr <= tmr - CNT_ONE;
          end
        end

        S_GAP: begin
          if (tmr == '0) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            tmr <= tmr - CNT_ONE;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_param_loop_scheduler.sv
// Bench for param_loop_scheduler: table of transactions driven against a CPU ack model,
// with a scoreboard queue checking every done/err pulse.
module tb_param_loop_scheduler;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int TMO     = 16;
  localparam int GAP     = 4;

  localparam int M_NORM  = 0;
  localparam int M_NOACK = 1;
  localparam int M_HOLD  = 2;
  localparam int M_PRE   = 3;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic [NUM_REQ-1:0] req = '0;
  logic [NUM_REQ-1:0] done;
  logic [NUM_REQ-1:0] err;
  logic               busy;
  logic [ID_W-1:0]    active_id;
  logic               loop_trig;
  logic               loop_ack = 1'b0;

  param_loop_scheduler #(
    .NUM_REQ    (NUM_REQ),
    .ID_W       (ID_W),
    .TIMEOUT_CYC(TMO),
    .GAP_CYC    (GAP)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .done     (done),
    .err      (err),
    .busy     (busy),
    .active_id(active_id),
    .loop_trig(loop_trig),
    .loop_ack (loop_ack)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0] oh;
    logic       is_err;
  } exp_t;

  typedef struct {
    logic       rst_first;
    logic [3:0] req;
    logic [3:0] req_mid;
    int         mode;
    logic [1:0] exp_id;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic sig_of(input int which);
    return (which == 0) ? busy : loop_trig;
  endfunction

  // Waits (bounded) for busy (which=0) or loop_trig (which=1) to reach val; cyc = negedges waited.
  task automatic wait_sig(input string name, input int which, input logic val,
                          input int limit, output int cyc);
    cyc = 0;
    while (sig_of(which) !== val && cyc < limit) begin
      tick(1);
      cyc++;
    end
    check(name, 32'(sig_of(which)), 32'(val));
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  // Scoreboard: every done/err pulse must match the oldest outstanding grant.
  always @(negedge clk) begin
    if (!reset && (done != '0 || err != '0)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", 32'({err, done}), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("pulse_done", 32'(done), e.is_err ? 32'd0 : 32'(e.oh));
        check("pulse_err", 32'(err), e.is_err ? 32'(e.oh) : 32'd0);
      end
    end
  end

  task automatic run_txn(input int mode);
    int c;
    case (mode)
      M_NORM: begin
        tick(10);
        loop_ack = 1'b1;
        wait_sig("trig_rise", 1, 1'b1, 40, c);
        tick(5);
        loop_ack = 1'b0;
        wait_sig("busy_fall", 0, 1'b0, 60, c);
      end
      M_NOACK: begin
        c = 0;
        while (loop_trig === 1'b0 && c < 100) begin
          tick(1);
          c++;
        end
        check("trig_low_cycles", 32'(c), 32'(TMO));
        wait_sig("busy_fall", 0, 1'b0, 60, c);
      end
      M_HOLD: begin
        tick(3);
        loop_ack = 1'b1;
        wait_sig("trig_rise", 1, 1'b1, 40, c);
        c = 0;
        while (err === '0 && c < 100) begin
          tick(1);
          c++;
        end
        check("release_tmo_cycles", 32'(c), 32'(TMO));
        wait_sig("busy_fall", 0, 1'b0, 60, c);
      end
      default: begin
        wait_sig("trig_rise_pre", 1, 1'b1, 40, c);
        check("pre_ack_trig_cycles", 32'(c), 32'd1);
        tick(6);
        loop_ack = 1'b0;
        wait_sig("busy_fall", 0, 1'b0, 60, c);
      end
    endcase
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1);
  end

  initial begin
    int c;
    exp_t e;

    vecs[0]  = '{1'b0, 4'b1111, 4'b1111, M_NORM,  2'd1};
    vecs[1]  = '{1'b0, 4'b1111, 4'b1111, M_NORM,  2'd2};
    vecs[2]  = '{1'b0, 4'b1111, 4'b1111, M_NORM,  2'd3};
    vecs[3]  = '{1'b0, 4'b1111, 4'b1111, M_NORM,  2'd0};
    vecs[4]  = '{1'b1, 4'b0101, 4'b0101, M_NORM,  2'd0};
    vecs[5]  = '{1'b0, 4'b0101, 4'b0101, M_NORM,  2'd2};
    vecs[6]  = '{1'b0, 4'b0101, 4'b0101, M_NORM,  2'd0};
    vecs[7]  = '{1'b0, 4'b0101, 4'b0101, M_NORM,  2'd2};
    vecs[8]  = '{1'b0, 4'b0101, 4'b0111, M_NORM,  2'd0};
    vecs[9]  = '{1'b0, 4'b0111, 4'b0111, M_NORM,  2'd1};
    vecs[10] = '{1'b0, 4'b0111, 4'b0111, M_NORM,  2'd2};
    vecs[11] = '{1'b0, 4'b0011, 4'b0011, M_NOACK, 2'd0};
    vecs[12] = '{1'b0, 4'b0011, 4'b0011, M_NORM,  2'd1};
    vecs[13] = '{1'b0, 4'b0100, 4'b0100, M_HOLD,  2'd2};
    vecs[14] = '{1'b0, 4'b1000, 4'b1000, M_PRE,   2'd3};

    // Reset values
    tick(2);
    check("rst_trig", 32'(loop_trig), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_id", 32'(active_id), 32'd0);
    check("rst_pulses", 32'({err, done}), 32'd0);
    reset = 1'b0;
    tick(1);

    // Single request with exact handshake timing
    req = 4'b0001;
    check("idle_trig", 32'(loop_trig), 32'd1);
    tick(1);
    check("single_trig_low", 32'(loop_trig), 32'd0);
    check("single_busy", 32'(busy), 32'd1);
    check("single_id", 32'(active_id), 32'd0);
    e.oh = 4'b0001;
    e.is_err = 1'b0;
    exp_q.push_back(e);
    tick(10);
    loop_ack = 1'b1;
    tick(2);
    check("trig_still_low", 32'(loop_trig), 32'd0);
    tick(1);
    check("trig_rise_3cyc", 32'(loop_trig), 32'd1);
    tick(5);
    loop_ack = 1'b0;
    req = 4'b0000;
    tick(2);
    check("done_not_yet", 32'(done), 32'd0);
    tick(1);
    check("done_pulse", 32'(done), 32'b0001);
    tick(1);
    check("done_one_cycle", 32'(done), 32'd0);
    loop_ack = 1'b1;
    tick(1);
    loop_ack = 1'b0;
    tick(1);
    check("gap_busy", 32'(busy), 32'd1);
    tick(1);
    check("busy_drop", 32'(busy), 32'd0);
    tick(3);
    check("gap_glitch_ignored", 32'({busy, loop_trig}), 32'b01);

    // Table-driven transactions
    for (int i = 0; i < 15; i++) begin
      vec_t v;
      v = vecs[i];
      if (v.rst_first) apply_reset();
      req = v.req;
      wait_sig("grant", 0, 1'b1, 20, c);
      check("grant_latency", 32'(c), 32'd1);
      check("grant_id", 32'(active_id), 32'(v.exp_id));
      check("grant_trig_low", 32'(loop_trig), 32'd0);
      e.oh = 4'(4'b0001 << v.exp_id);
      e.is_err = (v.mode == M_NOACK) || (v.mode == M_HOLD);
      exp_q.push_back(e);
      req = v.req_mid;
      run_txn(v.mode);
      check("id_hold", 32'(active_id), 32'(v.exp_id));
    end

    // Async reset while in TRIG aborts silently; rotation restarts at requester 0
    req = 4'b0010;
    wait_sig("grant_pre_rst", 0, 1'b1, 20, c);
    check("grant_pre_rst_id", 32'(active_id), 32'd1);
    tick(3);
    reset = 1'b1;
    #1;
    check("rst_mid_trig", 32'(loop_trig), 32'd1);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_pulses", 32'({err, done}), 32'd0);
    check("rst_mid_id", 32'(active_id), 32'd0);
    tick(2);
    reset = 1'b0;
    req = 4'b0011;
    wait_sig("grant_post_rst", 0, 1'b1, 20, c);
    check("grant_post_rst_id", 32'(active_id), 32'd0);
    e.oh = 4'b0001;
    e.is_err = 1'b0;
    exp_q.push_back(e);
    req = 4'b0000;
    run_txn(M_NORM);

    tick(5);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
